demux1_4_buf: RTL and testbench

//  Registered 1:4 stream demultiplexer, the distribution-side counterpart of the 4:1 mux select path.
//  - Routes one valid/ready input stream to one of 4 output channels chosen per beat by sel_in.
//  - Each channel holds a one-entry output buffer and keeps a saturating beat counter.
//  - Sits between a single producer and four independent consumers.

---
 rtl/demux1_4_buf_pkg.sv | 17 +
 rtl/demux1_4_buf_if.sv | 28 ++
 rtl/demux1_4_buf_slot.sv | 53 +++++
 rtl/demux1_4_buf.sv | 49 ++++
 tb/tb_demux1_4_buf.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux1_4_buf_pkg.sv
// Shared constants and helpers for the 1:4 buffered stream demultiplexer.
package demux1_4_buf_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  function automatic ch_vec_t sel_onehot(input sel_t s);
    ch_vec_t oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux1_4_buf_if.sv
// Producer/consumer bus of the demux: one input stream, four output channels, counters.
interface demux1_4_buf_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  import demux1_4_buf_pkg::*;

  logic [DATA_W-1:0]        a_in;
  logic [SEL_W-1:0]         sel_in;
  logic                     valid_in;
  logic                     ready_out;
  logic [NUM_CH*DATA_W-1:0] y_out;
  logic [NUM_CH-1:0]        valid_out;
  logic [NUM_CH-1:0]        ready_in;
  logic                     clr_cnt_in;
  logic [NUM_CH*CNT_W-1:0]  cnt_out;

  modport slave (
    input  a_in, sel_in, valid_in, ready_in, clr_cnt_in,
    output ready_out, y_out, valid_out, cnt_out
  );

  modport master (
    output a_in, sel_in, valid_in, ready_in, clr_cnt_in,
    input  ready_out, y_out, valid_out, cnt_out
  );

endinterface

// File: rtl/demux1_4_buf_slot.sv
// One output channel: single-entry buffer, valid flag and saturating pop counter.
module demux1_4_buf_slot #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              rdy_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Space is free if empty or the held beat leaves this cycle.
  assign rdy_o   = ~valid_q | pop_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign cnt_o   = cnt_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (pop_i)  valid_d = 1'b0;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
    if (clr_i)                    cnt_d = '0;
    else if (pop_i && ~&cnt_q)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/demux1_4_buf.sv
// Registered 1:4 stream demux: routes each accepted beat to the channel picked by sel_in.
module demux1_4_buf
  import demux1_4_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic           clock,
  input  logic           reset,
  demux1_4_buf_if.slave  bus
);

  logic [NUM_CH-1:0]             push_vec;
  logic [NUM_CH-1:0]             pop_vec;
  logic [NUM_CH-1:0]             rdy_vec;
  logic [NUM_CH-1:0]             valid_vec;
  logic [NUM_CH-1:0][DATA_W-1:0] data_vec;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_vec;
  logic                          accept;

  // Held low during reset so no beat is taken while state is being cleared.
  assign bus.ready_out = ~reset & rdy_vec[bus.sel_in];
  assign accept        = bus.valid_in & bus.ready_out;
  assign push_vec      = {NUM_CH{accept}} & sel_onehot(bus.sel_in);
  assign pop_vec       = valid_vec & bus.ready_in;

  assign bus.valid_out = valid_vec;
  assign bus.y_out     = data_vec;
  assign bus.cnt_out   = cnt_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux1_4_buf_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_vec[i]),
      .pop_i   (pop_vec[i]),
      .clr_i   (bus.clr_cnt_in),
      .data_i  (bus.a_in),
      .data_o  (data_vec[i]),
      .valid_o (valid_vec[i]),
      .rdy_o   (rdy_vec[i]),
      .cnt_o   (cnt_vec[i])
    );
  end

endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed and randomised checks of the 1:4 buffered demux (4-bit counters to reach saturation).
module tb_demux1_4_buf;

  localparam int DW = 8;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  demux1_4_buf_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  demux1_4_buf #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] ych(input int i);
    return bus.y_out[i*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cch(input int i);
    return bus.cnt_out[i*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in   = 1'b0;
    bus.sel_in     = '0;
    bus.a_in       = '0;
    bus.ready_in   = 4'hF;
    bus.clr_cnt_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.ready_in = 4'b0010;
    bus.valid_in = 1'b1;
    bus.sel_in = 2'd1; bus.a_in = 8'h11; tick();
    bus.sel_in = 2'd0; bus.a_in = 8'h01; tick();
    bus.sel_in = 2'd2; bus.a_in = 8'h02; tick();
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if (bus.valid_out !== 4'b0101) begin
      errors++; $display("FAIL reset_pre_valid got=%b exp=%b", bus.valid_out, 4'b0101);
    end
    checks++;
    if (bus.cnt_out !== 16'h0010) begin
      errors++; $display("FAIL reset_pre_cnt got=%h exp=%h", bus.cnt_out, 16'h0010);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.valid_out !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got=%b exp=0000", bus.valid_out);
    end
    checks++;
    if (bus.cnt_out !== 16'h0000) begin
      errors++; $display("FAIL reset_cnt got=%h exp=0000", bus.cnt_out);
    end
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_out);
    end
    checks++;
    if (bus.y_out !== 32'h0) begin
      errors++; $display("FAIL reset_y got=%h exp=0", bus.y_out);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.ready_out);
    end
  endtask

  task automatic test_routing();
    bus.ready_in = 4'hF;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel_in = i[1:0];
      bus.a_in   = 8'hA0 + 8'(i);
      tick();
      checks++;
      if (ych(i) !== 8'hA0 + 8'(i) || bus.valid_out[i] !== 1'b1) begin
        errors++; $display("FAIL route_ch%0d y=%h v=%b exp y=%h v=1", i, ych(i), bus.valid_out[i], 8'hA0 + 8'(i));
      end
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.cnt_out !== 16'h1111) begin
      errors++; $display("FAIL route_cnt got=%h exp=1111", bus.cnt_out);
    end
    checks++;
    if (bus.y_out !== 32'hA3A2A1A0 || bus.valid_out !== 4'b0000) begin
      errors++; $display("FAIL route_hold y=%h v=%b exp y=a3a2a1a0 v=0000", bus.y_out, bus.valid_out);
    end
  endtask

  task automatic test_backpressure();
    bus.clr_cnt_in = 1'b1; tick(); bus.clr_cnt_in = 1'b0;
    bus.ready_in = 4'b1011;
    bus.valid_in = 1'b1;
    bus.sel_in = 2'd2; bus.a_in = 8'h11; tick();
    bus.a_in = 8'h22;
    #1;
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++; $display("FAIL bp_stall_ready got=%b exp=0", bus.ready_out);
    end
    bus.sel_in = 2'd1; bus.a_in = 8'h33;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL bp_other_ready got=%b exp=1", bus.ready_out);
    end
    tick();
    checks++;
    if (ych(1) !== 8'h33 || bus.valid_out[1] !== 1'b1 || ych(2) !== 8'h11) begin
      errors++; $display("FAIL bp_other_push y1=%h v1=%b y2=%h exp 33 1 11", ych(1), bus.valid_out[1], ych(2));
    end
    bus.sel_in = 2'd2; bus.a_in = 8'h22; tick();
    checks++;
    if (ych(2) !== 8'h11 || bus.valid_out[2] !== 1'b1) begin
      errors++; $display("FAIL bp_hold y2=%h v2=%b exp 11 1", ych(2), bus.valid_out[2]);
    end
    bus.ready_in[2] = 1'b1;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.ready_out);
    end
    tick();
    checks++;
    if (ych(2) !== 8'h22 || bus.valid_out[2] !== 1'b1) begin
      errors++; $display("FAIL bp_second y2=%h v2=%b exp 22 1", ych(2), bus.valid_out[2]);
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.cnt_out !== 16'h0210 || bus.valid_out !== 4'b0000) begin
      errors++; $display("FAIL bp_cnt cnt=%h v=%b exp 0210 0000", bus.cnt_out, bus.valid_out);
    end
  endtask

  task automatic test_push_pop();
    bus.clr_cnt_in = 1'b1; tick(); bus.clr_cnt_in = 1'b0;
    bus.ready_in = 4'b0111;
    bus.valid_in = 1'b1;
    bus.sel_in = 2'd3; bus.a_in = 8'hA5; tick();
    checks++;
    if (bus.valid_out[3] !== 1'b1 || ych(3) !== 8'hA5) begin
      errors++; $display("FAIL pp_fill v3=%b y3=%h exp 1 a5", bus.valid_out[3], ych(3));
    end
    bus.ready_in[3] = 1'b1;
    bus.a_in = 8'h5A;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++; $display("FAIL pp_ready got=%b exp=1", bus.ready_out);
    end
    tick();
    checks++;
    if (ych(3) !== 8'h5A || bus.valid_out[3] !== 1'b1) begin
      errors++; $display("FAIL pp_data y3=%h v3=%b exp 5a 1", ych(3), bus.valid_out[3]);
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (bus.valid_out[3] !== 1'b0 || bus.cnt_out !== 16'h2000) begin
      errors++; $display("FAIL pp_drain v3=%b cnt=%h exp 0 2000", bus.valid_out[3], bus.cnt_out);
    end
  endtask

  task automatic test_saturation();
    bus.clr_cnt_in = 1'b1; tick(); bus.clr_cnt_in = 1'b0;
    bus.ready_in = 4'hF;
    bus.valid_in = 1'b1;
    bus.sel_in   = 2'd0;
    for (int k = 0; k < 20; k++) begin
      bus.a_in = 8'(k);
      tick();
      if (k == 14) begin
        checks++;
        if (cch(0) !== 4'd14) begin
          errors++; $display("FAIL sat_count14 got=%0d exp=14", cch(0));
        end
      end
    end
    bus.valid_in = 1'b0;
    tick();
    checks++;
    if (cch(0) !== 4'd15) begin
      errors++; $display("FAIL sat_cap got=%0d exp=15", cch(0));
    end
    bus.valid_in = 1'b1; bus.a_in = 8'hEE; tick();
    bus.valid_in = 1'b0; bus.clr_cnt_in = 1'b1; tick();
    bus.clr_cnt_in = 1'b0;
    checks++;
    if (bus.cnt_out !== 16'h0000 || bus.valid_out[0] !== 1'b0 || ych(0) !== 8'hEE) begin
      errors++; $display("FAIL sat_clr_pop cnt=%h v0=%b y0=%h exp 0000 0 ee", bus.cnt_out, bus.valid_out[0], ych(0));
    end
  endtask

  task automatic test_random();
    logic          mv[4];
    logic [DW-1:0] md[4];
    logic [CW-1:0] mc[4];
    logic          stall, exp_rdy;
    int            accepted, delivered;
    bus.clr_cnt_in = 1'b1; tick(); bus.clr_cnt_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; md[i] = ych(i); mc[i] = '0;
    end
    stall = 1'b0; accepted = 0; delivered = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus.valid_out[i] !== mv[i] || ych(i) !== md[i] || cch(i) !== mc[i]) begin
          errors++;
          $display("FAIL rnd_state c=%0d ch%0d v=%b y=%h cnt=%0d exp v=%b y=%h cnt=%0d",
                   c, i, bus.valid_out[i], ych(i), cch(i), mv[i], md[i], mc[i]);
        end
      end
      if (!stall) begin
        bus.valid_in = ($urandom_range(0, 9) < 7);
        bus.sel_in   = 2'($urandom_range(0, 3));
        bus.a_in     = 8'($urandom);
      end
      bus.ready_in   = 4'($urandom);
      bus.clr_cnt_in = ($urandom_range(0, 63) == 0);
      #1;
      exp_rdy = ~mv[bus.sel_in] | bus.ready_in[bus.sel_in];
      checks++;
      if (bus.ready_out !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.ready_out, exp_rdy);
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.valid_out[i] && bus.ready_in[i]) delivered++;
        if (mv[i] && bus.ready_in[i]) mv[i] = 1'b0;
        if (bus.clr_cnt_in) mc[i] = '0;
        else if (bus.valid_out[i] && bus.ready_in[i] && mc[i] != 4'hF) mc[i] = mc[i] + 1'b1;
      end
      if (bus.valid_in && exp_rdy) begin
        mv[bus.sel_in] = 1'b1;
        md[bus.sel_in] = bus.a_in;
        accepted++;
      end
      stall = bus.valid_in & ~exp_rdy;
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) if (bus.valid_out[i]) delivered++;
      tick();
    end
    checks++;
    if (delivered !== accepted || bus.valid_out !== 4'b0000) begin
      errors++; $display("FAIL rnd_total delivered=%0d accepted=%0d v=%b", delivered, accepted, bus.valid_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #12 reset = 1'b0;
    tick();
    test_reset();
    test_routing();
    test_backpressure();
    test_push_pop();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
